// File: rtl/hd44780_nybble_writer_pkg.sv
// Shared definitions for the HD44780 4-bit writer: state encodings, command codes,
// cycle-count derivations from the system clock frequency and the power-on init table.
package hd44780_nybble_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_E_HI     = 3'd2,
        ST_E_LO     = 3'd3,
        ST_POST     = 3'd4,
        ST_INIT_PWR = 3'd5
    } state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // 53 us command execution time
    function automatic int cmd_dly_cyc(input int sysfreq);
        return (sysfreq / 1000) * 53 / 1000;
    endfunction

    // 3 ms clear/home execution time
    function automatic int long_dly_cyc(input int sysfreq);
        return (sysfreq / 1000) * 3;
    endfunction

    // 100 ms power-on settle
    function automatic int init_pwr_cyc(input int sysfreq);
        return sysfreq / 10;
    endfunction

    // 4.1 ms gap after the first init nibble
    function automatic int init_long_cyc(input int sysfreq);
        return (sysfreq / 10000) * 41;
    endfunction

    // 100 us gap after the remaining init nibbles
    function automatic int init_short_cyc(input int sysfreq);
        return sysfreq / 10000;
    endfunction

    // Init nibble sequence 3, 3, 3, 2 indexed 0..3
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // Clear and home (0x00..0x03 with RS=0) need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return (rs == 1'b0) && ((b & ~(CMD_CLEAR | CMD_HOME)) == 8'h00);
    endfunction

endpackage

// File: rtl/hd44780_nybble_writer_if.sv
// Write-request handshake between the message/controller logic and the LCD writer.
interface hd44780_nybble_writer_if;
    logic [7:0] DAT_I;
    logic       RS_I;
    logic       NYB_I;
    logic       STB_I;
    logic       RDY_O;

    modport master (output DAT_I, output RS_I, output NYB_I, output STB_I, input RDY_O);
    modport slave  (input DAT_I, input RS_I, input NYB_I, input STB_I, output RDY_O);
endinterface

// File: rtl/hd44780_delay_ctr.sv
// Loadable down-counter for the writer's timed states; holds at zero and flags done there.
module hd44780_delay_ctr #(
    parameter int TMR_BITS = 23
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [TMR_BITS-1:0] load_val_i,
    output logic                done_o
);

    logic [TMR_BITS-1:0] count_q;
    logic [TMR_BITS-1:0] count_d;

    // Next count: load wins, otherwise count down and saturate at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - TMR_BITS'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/hd44780_nybble_writer.sv
// HD44780 4-bit write-only sequencer: {RS, byte} in, framed nibbles with E pulses out.
// Define HD44780_INIT_SEQ_EN to run the power-on init sequence before accepting writes.
module hd44780_nybble_writer
    import hd44780_nybble_writer_pkg::*;
#(
    parameter int SYSFREQ      = 48_000_000,
    parameter int SETUP_CYC    = 4,
    parameter int E_HI_CYC     = 24,
    parameter int E_LO_CYC     = 24,
    parameter int CMD_DLY_CYC  = cmd_dly_cyc(SYSFREQ),
    parameter int LONG_DLY_CYC = long_dly_cyc(SYSFREQ),
    parameter int TMR_BITS     = $clog2(SYSFREQ / 10)
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    hd44780_nybble_writer_if.slave        bus,
    output logic                          lcd_rs,
    output logic                          lcd_e,
    output logic [3:0]                    lcd_data
);

    // Counter load values are one less than the state length: done fires on the last cycle
    localparam logic [TMR_BITS-1:0] LD_SETUP = TMR_BITS'(SETUP_CYC - 1);
    localparam logic [TMR_BITS-1:0] LD_E_HI  = TMR_BITS'(E_HI_CYC - 1);
    localparam logic [TMR_BITS-1:0] LD_E_LO  = TMR_BITS'(E_LO_CYC - 1);
    localparam logic [TMR_BITS-1:0] LD_CMD   = TMR_BITS'(CMD_DLY_CYC - 1);
    localparam logic [TMR_BITS-1:0] LD_LONG  = TMR_BITS'(LONG_DLY_CYC - 1);

`ifdef HD44780_INIT_SEQ_EN
    // Power-on wait starts from reset release, so the first edge already counts
    localparam logic [TMR_BITS-1:0] LD_PWR        = TMR_BITS'(init_pwr_cyc(SYSFREQ) - 2);
    localparam logic [TMR_BITS-1:0] LD_INIT_LONG  = TMR_BITS'(init_long_cyc(SYSFREQ) - 1);
    localparam logic [TMR_BITS-1:0] LD_INIT_SHORT = TMR_BITS'(init_short_cyc(SYSFREQ) - 1);
    localparam state_t RESET_STATE = ST_INIT_PWR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t       state_q, state_d;
    logic [7:0]   byte_q, byte_d;
    logic         rs_q, rs_d;
    logic         nyb_q, nyb_d;
    logic         second_q, second_d;
    logic         lcd_rs_q, lcd_rs_d;
    logic         lcd_e_q, lcd_e_d;
    logic [3:0]   lcd_data_q, lcd_data_d;
`ifdef HD44780_INIT_SEQ_EN
    logic         init_q, init_d;
    logic [1:0]   idx_q, idx_d;
    logic         armed_q, armed_d;
`endif

    logic                ctr_load;
    logic [TMR_BITS-1:0] ctr_val;
    logic                ctr_done;
    logic [TMR_BITS-1:0] post_ld;

    hd44780_delay_ctr #(
        .TMR_BITS (TMR_BITS)
    ) u_delay_ctr (
        .clk_i      (CLK_I),
        .rst_i      (RST_I),
        .load_i     (ctr_load),
        .load_val_i (ctr_val),
        .done_o     (ctr_done)
    );

    // Post-write wait length for the latched byte
    always_comb begin
`ifdef HD44780_INIT_SEQ_EN
        if (init_q) begin
            post_ld = (idx_q == 2'd0) ? LD_INIT_LONG : LD_INIT_SHORT;
        end else begin
            post_ld = is_long_cmd(rs_q, byte_q) ? LD_LONG : LD_CMD;
        end
`else
        post_ld = is_long_cmd(rs_q, byte_q) ? LD_LONG : LD_CMD;
`endif
    end

    // Next-state and output-register decode
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        rs_d       = rs_q;
        nyb_d      = nyb_q;
        second_d   = second_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_e_d    = lcd_e_q;
        lcd_data_d = lcd_data_q;
        ctr_load   = 1'b0;
        ctr_val    = '0;
`ifdef HD44780_INIT_SEQ_EN
        init_d     = init_q;
        idx_d      = idx_q;
        armed_d    = armed_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.STB_I) begin
                    byte_d     = bus.DAT_I;
                    rs_d       = bus.RS_I;
                    nyb_d      = bus.NYB_I;
                    second_d   = 1'b0;
                    lcd_rs_d   = bus.RS_I;
                    lcd_data_d = bus.DAT_I[7:4];
                    state_d    = ST_SETUP;
                    ctr_load   = 1'b1;
                    ctr_val    = LD_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (ctr_done) begin
                    lcd_e_d  = 1'b1;
                    state_d  = ST_E_HI;
                    ctr_load = 1'b1;
                    ctr_val  = LD_E_HI;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_E_HI: begin
                if (ctr_done) begin
                    lcd_e_d  = 1'b0;
                    state_d  = ST_E_LO;
                    ctr_load = 1'b1;
                    ctr_val  = LD_E_LO;
                end else begin
                    state_d = ST_E_HI;
                end
            end
            ST_E_LO: begin
                if (ctr_done && !nyb_q && !second_q) begin
                    second_d   = 1'b1;
                    lcd_data_d = byte_q[3:0];
                    state_d    = ST_SETUP;
                    ctr_load   = 1'b1;
                    ctr_val    = LD_SETUP;
                end else if (ctr_done) begin
                    state_d  = ST_POST;
                    ctr_load = 1'b1;
                    ctr_val  = post_ld;
                end else begin
                    state_d = ST_E_LO;
                end
            end
            ST_POST: begin
                if (ctr_done) begin
`ifdef HD44780_INIT_SEQ_EN
                    if (init_q && (idx_q != 2'd3)) begin
                        idx_d      = idx_q + 2'd1;
                        byte_d     = {init_nibble(idx_q + 2'd1), 4'h0};
                        lcd_data_d = init_nibble(idx_q + 2'd1);
                        lcd_rs_d   = 1'b0;
                        state_d    = ST_SETUP;
                        ctr_load   = 1'b1;
                        ctr_val    = LD_SETUP;
                    end else begin
                        init_d   = 1'b0;
                        state_d  = ST_IDLE;
                        ctr_load = 1'b1;
                        ctr_val  = '0;
                    end
`else
                    state_d  = ST_IDLE;
                    ctr_load = 1'b1;
                    ctr_val  = '0;
`endif
                end else begin
                    state_d = ST_POST;
                end
            end
`ifdef HD44780_INIT_SEQ_EN
            ST_INIT_PWR: begin
                if (!armed_q) begin
                    armed_d  = 1'b1;
                    ctr_load = 1'b1;
                    ctr_val  = LD_PWR;
                end else if (ctr_done) begin
                    idx_d      = 2'd0;
                    byte_d     = {init_nibble(2'd0), 4'h0};
                    rs_d       = 1'b0;
                    nyb_d      = 1'b1;
                    second_d   = 1'b0;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = init_nibble(2'd0);
                    state_d    = ST_SETUP;
                    ctr_load   = 1'b1;
                    ctr_val    = LD_SETUP;
                end else begin
                    state_d = ST_INIT_PWR;
                end
            end
`endif
            default: begin
                lcd_e_d = 1'b0;
                state_d = RESET_STATE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= RESET_STATE;
            byte_q     <= 8'h00;
            rs_q       <= 1'b0;
            nyb_q      <= 1'b0;
            second_q   <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_data_q <= 4'h0;
`ifdef HD44780_INIT_SEQ_EN
            init_q     <= 1'b1;
            idx_q      <= 2'd0;
            armed_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            rs_q       <= rs_d;
            nyb_q      <= nyb_d;
            second_q   <= second_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_e_q    <= lcd_e_d;
            lcd_data_q <= lcd_data_d;
`ifdef HD44780_INIT_SEQ_EN
            init_q     <= init_d;
            idx_q      <= idx_d;
            armed_q    <= armed_d;
`endif
        end
    end

    assign lcd_rs    = lcd_rs_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_data  = lcd_data_q;
    assign bus.RDY_O = (state_q == ST_IDLE);

endmodule
